// File: rtl/kws_pkg.sv
// rtl/kws_pkg.sv - shared constants, feature type and read FSM states for the CMVN frame collector
package kws_pkg;

    localparam int NUM_BINS = 20;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    // Signed 1.7.24 fixed-point feature as produced by the CMVN normaliser.
    typedef logic signed [DATA_W-1:0] feature_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rd_state_t;

endpackage

// File: rtl/cmvn_frame_bank.sv
// rtl/cmvn_frame_bank.sv - 2 x NUM_BINS x DATA_W ping-pong register file, sync write, comb read
module cmvn_frame_bank
    import kws_pkg::*;
#(
    parameter int NUM_BINS = kws_pkg::NUM_BINS,
    parameter int DATA_W   = kws_pkg::DATA_W,
    parameter int ADDR_W   = kws_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Contents need no reset: the top never presents a bin it has not written.
    logic [DATA_W-1:0] mem [2][NUM_BINS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/cmvn_frame_collector.sv
// rtl/cmvn_frame_collector.sv - collects CMVN bins into ping-pong frames and replays them; option CMVN_COLL_LEVEL_VALID_EN
module cmvn_frame_collector
    import kws_pkg::*;
#(
    parameter int NUM_BINS = kws_pkg::NUM_BINS,
    parameter int DATA_W   = kws_pkg::DATA_W,
    parameter int ADDR_W   = kws_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              overflow,
    output logic              addr_err,
    output logic [15:0]       frame_cnt
);

    localparam logic [NUM_BINS-1:0] ALL_ONES = '1;
    localparam logic [NUM_BINS-1:0] BIT0     = NUM_BINS'(1);
    localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(NUM_BINS - 1);

    rd_state_t                  state, state_d;
    logic [1:0][NUM_BINS-1:0]   fill_mask, fill_mask_d;
    logic [1:0]                 bank_full, bank_full_d;
    logic                       wr_bank, wr_bank_d;
    logic                       rd_bank, rd_bank_d;
    logic [ADDR_W-1:0]          rd_idx, rd_idx_d;
    logic [NUM_BINS-1:0]        mask_next;
    logic                       sample;
    logic                       addr_ok;
    logic                       wr_en;
    logic                       set_overflow;
    logic                       set_addr_err;
    logic                       frame_done;
    logic [DATA_W-1:0]          rd_data;

`ifdef CMVN_COLL_LEVEL_VALID_EN
    // Level-valid upstream: a new sample is a rising in_valid or a change of bin while held.
    logic              prev_valid;
    logic [ADDR_W-1:0] last_addr;

    assign sample = in_valid && (!prev_valid || (in_addr != last_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            last_addr  <= '0;
        end else if (clear) begin
            prev_valid <= 1'b0;
            last_addr  <= '0;
        end else begin
            prev_valid <= in_valid;
            if (sample) begin
                last_addr <= in_addr;
            end
        end
    end
`else
    assign sample = in_valid;
`endif

    assign addr_ok = int'(in_addr) < NUM_BINS;

    always_comb begin
        wr_en        = 1'b0;
        set_overflow = 1'b0;
        set_addr_err = 1'b0;
        frame_done   = 1'b0;
        mask_next    = fill_mask[wr_bank] | (BIT0 << in_addr);
        fill_mask_d  = fill_mask;
        bank_full_d  = bank_full;
        wr_bank_d    = wr_bank;
        rd_bank_d    = rd_bank;
        rd_idx_d     = rd_idx;
        state_d      = state;

        if (sample) begin
            if (!addr_ok) begin
                set_addr_err = 1'b1;
            end else if (bank_full[wr_bank]) begin
                set_overflow = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (mask_next == ALL_ONES) begin
                    fill_mask_d[wr_bank] = '0;
                    bank_full_d[wr_bank] = 1'b1;
                    wr_bank_d            = ~wr_bank;
                end else begin
                    fill_mask_d[wr_bank] = mask_next;
                end
            end
        end

        // Read side looks at post-write fullness so a frame completed this cycle is seen next cycle.
        case (state)
            R_IDLE: begin
                if (bank_full_d[rd_bank]) begin
                    state_d = R_STREAM;
                end
            end
            R_STREAM: begin
                if (out_ready) begin
                    if (rd_idx == LAST_IDX) begin
                        frame_done           = 1'b1;
                        rd_idx_d             = '0;
                        bank_full_d[rd_bank] = 1'b0;
                        rd_bank_d            = ~rd_bank;
                        state_d              = bank_full_d[~rd_bank] ? R_STREAM : R_IDLE;
                    end else begin
                        rd_idx_d = rd_idx + 1'b1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
        end else if (clear) begin
            state <= R_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_mask <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            overflow  <= 1'b0;
            addr_err  <= 1'b0;
            frame_cnt <= '0;
        end else if (clear) begin
            fill_mask <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            overflow  <= 1'b0;
            addr_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            fill_mask <= fill_mask_d;
            bank_full <= bank_full_d;
            wr_bank   <= wr_bank_d;
            rd_bank   <= rd_bank_d;
            rd_idx    <= rd_idx_d;
            if (set_overflow) begin
                overflow <= 1'b1;
            end
            if (set_addr_err) begin
                addr_err <= 1'b1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    cmvn_frame_bank #(
        .NUM_BINS (NUM_BINS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (in_addr),
        .wr_data (in_data),
        .rd_bank (rd_bank),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    assign out_valid = (state == R_STREAM);
    assign out_data  = out_valid ? rd_data : '0;
    assign out_addr  = out_valid ? rd_idx : '0;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_cmvn_frame_collector.sv
// tb/tb_cmvn_frame_collector.sv - randomized bench with a frame-queue reference model for cmvn_frame_collector
module tb_cmvn_frame_collector;

    localparam int NB = 20;
`ifdef CMVN_COLL_LEVEL_VALID_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        overflow;
    logic        addr_err;
    logic [15:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmvn_frame_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .overflow  (overflow),
        .addr_err  (addr_err),
        .frame_cnt (frame_cnt)
    );

    // Reference: completed frames wait in a FIFO of at most two; the front one is replayed beat by beat.
    typedef logic [31:0] frame_t [NB];
    frame_t          pend[$];
    frame_t          part;
    logic [NB-1:0]   part_mask;
    int              beat;
    int              m_cnt;
    bit              m_ovf;
    bit              m_aerr;
    bit              m_prev_v;
    logic [4:0]      m_last_addr;

    function automatic void model_reset();
        pend.delete();
        part_mask   = '0;
        beat        = 0;
        m_cnt       = 0;
        m_ovf       = 1'b0;
        m_aerr      = 1'b0;
        m_prev_v    = 1'b0;
        m_last_addr = '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int sz;
        bit take;
        bit pop;
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            sz  = pend.size();
            pop = 1'b0;
            if (sz > 0 && out_ready) begin
                if (beat == NB - 1) pop = 1'b1;
                else beat++;
            end
`ifdef CMVN_COLL_LEVEL_VALID_EN
            take = in_valid && (!m_prev_v || in_addr != m_last_addr);
            m_prev_v = in_valid;
            if (take) m_last_addr = in_addr;
`else
            take = in_valid;
`endif
            if (take) begin
                if (int'(in_addr) >= NB) m_aerr = 1'b1;
                else if (sz == 2) m_ovf = 1'b1;
                else begin
                    part[in_addr]      = in_data;
                    part_mask[in_addr] = 1'b1;
                    if (&part_mask) begin
                        pend.push_back(part);
                        part_mask = '0;
                    end
                end
            end
            if (pop) begin
                void'(pend.pop_front());
                beat  = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ed;
        ev = pend.size() > 0;
        ed = ev ? pend[0][beat] : 32'd0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("out_data", out_data, ed);
        chk("out_addr", {27'd0, out_addr}, ev ? beat : 0);
        chk("out_last", {31'd0, out_last}, (ev && beat == NB - 1) ? 1 : 0);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
        chk("frame_cnt", {16'd0, frame_cnt}, m_cnt);
    end

    // Handshake log of what the DUT actually emitted, for the literal checks.
    int          log_addr[$];
    logic [31:0] log_data[$];
    bit          log_last[$];

    always @(posedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            log_addr.push_back(int'(out_addr));
            log_data.push_back(out_data);
            log_last.push_back(out_last);
        end
    end

    bit ready_rand = 1'b0;
    bit ready_val  = 1'b1;

    always @(negedge clk) begin
        #1;
        out_ready = ready_rand ? 1'($urandom_range(1, 0)) : ready_val;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input int a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = 5'(a);
        in_data  = d;
        repeat (HOLD) tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [31:0] base, input bit shuffle);
        int ord[NB];
        for (int i = 0; i < NB; i++) ord[i] = i;
        if (shuffle) begin
            for (int i = NB - 1; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(i, 0);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        end
        for (int i = 0; i < NB; i++) send(ord[i], base + 32'(ord[i]));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend.size() > 0 || out_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_timeout", (n < 3000) ? 1 : 0, 1);
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 0);
        chk({tag, "_aerr"}, {31'd0, addr_err}, 0);
        chk({tag, "_cnt"}, {16'd0, frame_cnt}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // In-order frame, data 100+i
        base = log_data.size();
        send_frame(32'd100, 1'b0);
        drain();
        chk("t1_cnt", {16'd0, frame_cnt}, 1);
        chk("t1_beats", log_data.size() - base, NB);
        for (int i = 0; i < NB; i++) begin
            chk("t1_data", log_data[base + i], 32'(100 + i));
            chk("t1_addr", log_addr[base + i], i);
        end
        chk("t1_last19", {31'd0, log_last[base + NB - 1]}, 1);
        chk("t1_last18", {31'd0, log_last[base + NB - 2]}, 0);

        // Reverse order with bin 5 overwritten by 7
        pulse_clear();
        base = log_data.size();
        for (int i = NB - 1; i >= 0; i--) begin
            send(i, 32'(200 + i));
            if (i == 5) send(5, 32'd7);
        end
        drain();
        chk("t2_cnt", {16'd0, frame_cnt}, 1);
        chk("t2_beats", log_data.size() - base, NB);
        chk("t2_bin5", log_data[base + 5], 32'd7);
        chk("t2_bin6", log_data[base + 6], 32'd206);

        // Three frames with downstream stalled: third is dropped
        pulse_clear();
        base = log_data.size();
        ready_val = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(32'(300 + 20 * f), 1'b0);
        repeat (3) tick();
        chk("t3_ovf", {31'd0, overflow}, 1);
        chk("t3_held", {31'd0, out_valid}, 1);
        ready_val = 1'b1;
        drain();
        chk("t3_cnt", {16'd0, frame_cnt}, 2);
        chk("t3_beats", log_data.size() - base, 2 * NB);
        chk("t3_f2b0", log_data[base + NB], 32'd320);
        chk("t3_f2b19", log_data[base + 2 * NB - 1], 32'd339);

        // Out-of-range bin
        pulse_clear();
        base = log_data.size();
        send(25, 32'hdead);
        chk("t4_aerr", {31'd0, addr_err}, 1);
        chk("t4_ovf", {31'd0, overflow}, 0);
        send_frame(32'd400, 1'b1);
        drain();
        chk("t4_cnt", {16'd0, frame_cnt}, 1);
        chk("t4_b0", log_data[base], 32'd400);

        // Random ready, back-to-back banks, random bins and data
        pulse_clear();
        ready_val = 1'b0;
        send_frame($urandom & 32'hffff_ff00, 1'b1);
        send_frame($urandom & 32'hffff_ff00, 1'b1);
        ready_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int cnt;
            cnt = 0;
            while (cnt < NB + 4) begin
                int a;
                a = ($urandom_range(9, 0) == 0) ? $urandom_range(31, 0) : $urandom_range(NB - 1, 0);
                send(a, $urandom);
                cnt++;
            end
            send_frame($urandom, 1'b1);
        end
        ready_rand = 1'b0;
        ready_val  = 1'b1;
        drain();

        // Async reset mid-frame, then clear mid-frame
        pulse_clear();
        for (int i = 0; i <= 10; i++) send(i, 32'(500 + i));
        rst_n = 1'b0;
        tick();
        tick();
        chk_all_zero("t6_rst");
        rst_n = 1'b1;
        tick();
        send_frame(32'd600, 1'b0);
        drain();
        chk("t6_cnt_a", {16'd0, frame_cnt}, 1);
        for (int i = 0; i <= 10; i++) send(i, 32'(700 + i));
        pulse_clear();
        chk_all_zero("t6_clr");
        base = log_data.size();
        send_frame(32'd800, 1'b1);
        drain();
        chk("t6_cnt_b", {16'd0, frame_cnt}, 1);
        chk("t6_beats", log_data.size() - base, NB);
        chk("t6_b10", log_data[base + 10], 32'd810);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
